// File: rtl/accum_sequencer.sv
// Purpose: control sequencer for the 17-bit switch accumulator (register, adder, router).
// Latency: Ld_Reg fires SYNC_STAGES+SETTLE_CYCLES+1 cycles after Run is first sampled low; Clr_Reg after SYNC_STAGES+1.
// Backpressure: none; one pulse per button press, further presses ignored until both buttons are released.
//
// Ports:
//   Clk            system clock, rising edge
//   Reset_Clear    asynchronous active-low reset
//   Run_Accumulate raw active-low Run button (asynchronous to Clk)
//   Clear_Button   raw active-low Clear button (asynchronous to Clk)
//   Cout           adder carry-out, valid once the sum has settled
//   Ld_Reg         one-cycle load enable for the accumulator register
//   Clr_Reg        one-cycle synchronous clear for the accumulator register
//   Busy           high whenever the sequencer is not idle
//   Overflow       sticky carry-out flag, cleared by a Clear press
//   Acc_Count      saturating count of completed loads

module accum_sequencer #(
  parameter int SETTLE_CYCLES = 4,  // 1..15
  parameter int SYNC_STAGES   = 2,  // 2..3
  parameter int COUNT_W       = 8
) (
  input  logic               Clk,
  input  logic               Reset_Clear,
  input  logic               Run_Accumulate,
  input  logic               Clear_Button,
  input  logic               Cout,
  output logic               Ld_Reg,
  output logic               Clr_Reg,
  output logic               Busy,
  output logic               Overflow,
  output logic [COUNT_W-1:0] Acc_Count
);

  localparam int            SET_W      = 4;
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    LOAD     = 3'd2,
    CLEAR    = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchronizers; reset to '1 so both buttons read as released.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] run_sync_q;
  logic [SYNC_STAGES-1:0] clr_sync_q;
  logic                   run_s;
  logic                   clr_s;

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      run_sync_q <= '1;
      clr_sync_q <= '1;
    end else begin
      run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], Run_Accumulate};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], Clear_Button};
    end
  end

  assign run_s = run_sync_q[SYNC_STAGES-1];
  assign clr_s = clr_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Clear wins over Run and aborts a pending settle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (!clr_s) begin
          state_d = CLEAR;
        end else if (!run_s) begin
          state_d  = SETTLE;
          settle_d = SETTLE_INIT;
        end
      end
      SETTLE: begin
        if (!clr_s) begin
          state_d = CLEAR;
        end else if (settle_q == '0) begin
          state_d = LOAD;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      LOAD:     state_d = WAIT_REL;
      CLEAR:    state_d = WAIT_REL;
      // A new press only counts after both buttons have been let go.
      WAIT_REL: if (run_s && clr_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Strobes are decoded from the next state and registered so
  // they line up exactly with the LOAD / CLEAR state cycle.
  // ---------------------------------------------------------------------------
  logic               ld_q, ld_d;
  logic               clr_q, clr_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    ld_d    = (state_d == LOAD);
    clr_d   = (state_d == CLEAR);
    busy_d  = (state_d != IDLE);
    ovf_d   = ovf_q;
    count_d = count_q;
    // Overflow/count update at the end of the one-cycle LOAD/CLEAR state, so
    // Cout is taken while the register is actually being loaded.
    if (state_q == LOAD) begin
      ovf_d = ovf_q | Cout;
      if (count_q != '1) count_d = count_q + COUNT_W'(1);
    end else if (state_q == CLEAR) begin
      ovf_d   = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      ld_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      ld_q    <= ld_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign Ld_Reg    = ld_q;
  assign Clr_Reg   = clr_q;
  assign Busy      = busy_q;
  assign Overflow  = ovf_q;
  assign Acc_Count = count_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Purpose: self-checking bench for accum_sequencer (default build plus a COUNT_W=2 build).
// Latency: expected pulse cycles are derived arithmetically from press/release times.
// Backpressure: n/a; button stimulus only.

module tb_accum_sequencer;

  localparam int S = 2;  // SYNC_STAGES
  localparam int T = 4;  // SETTLE_CYCLES

  logic       Clk = 1'b0;
  logic       Reset_Clear;
  logic       Run_Accumulate;
  logic       Clear_Button;
  logic       Cout;
  logic       ld, clr, busy, ovf;
  logic [7:0] cnt;
  logic       ld2, clr2, busy2, ovf2;
  logic [1:0] cnt2;

  always #5 Clk = ~Clk;

  accum_sequencer #(.SETTLE_CYCLES(T), .SYNC_STAGES(S), .COUNT_W(8)) dut (
    .Clk(Clk), .Reset_Clear(Reset_Clear), .Run_Accumulate(Run_Accumulate),
    .Clear_Button(Clear_Button), .Cout(Cout), .Ld_Reg(ld), .Clr_Reg(clr),
    .Busy(busy), .Overflow(ovf), .Acc_Count(cnt)
  );

  accum_sequencer #(.SETTLE_CYCLES(T), .SYNC_STAGES(S), .COUNT_W(2)) dut2 (
    .Clk(Clk), .Reset_Clear(Reset_Clear), .Run_Accumulate(Run_Accumulate),
    .Clear_Button(Clear_Button), .Cout(Cout), .Ld_Reg(ld2), .Clr_Reg(clr2),
    .Busy(busy2), .Overflow(ovf2), .Acc_Count(cnt2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: what the accumulator bookkeeping should read.
  int m_cnt  = 0;
  int m_cnt2 = 0;
  bit m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input bit e_ld, input bit e_clr, input bit e_busy);
    chk("ld", 32'(ld), 32'(e_ld));
    chk("clr", 32'(clr), 32'(e_clr));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("ld2", 32'(ld2), 32'(e_ld));
    chk("clr2", 32'(clr2), 32'(e_clr));
    chk("cnt2", 32'(cnt2), 32'(m_cnt2));
    chk("ovf2", 32'(ovf2), 32'(m_ovf));
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One button episode starting from IDLE. Relative cycle c: inputs driven in
  // cycle c are first sampled on edge c+1. Run held for cycles [0,h), Clear
  // held for [d,h). Clear seen by the FSM on edge d+S+1 wins if the run is
  // still idle or settling (d <= T).
  task automatic txn(input bit use_run, input bit use_clr, input int h, input int d,
                     input bit force_cout, input bit cval);
    int ld_c;
    int clr_c;
    int idle_c;
    if (use_clr) begin
      ld_c   = -1;
      clr_c  = d + S + 1;
      idle_c = imax(h + S + 1, d + S + 3);
    end else begin
      ld_c   = S + T + 1;
      clr_c  = -1;
      idle_c = imax(h + S + 1, S + T + 3);
    end
    for (int c = 0; c <= idle_c + 1; c++) begin
      if (c > 0) begin
        tick();
        check_all(c == ld_c, c == clr_c, (c >= S + 1) && (c < idle_c));
      end
      Cout           = force_cout ? cval : ($urandom_range(0, 3) == 0);
      Run_Accumulate = !(use_run && c < h);
      Clear_Button   = !(use_clr && c >= d && c < h);
      if (c == ld_c) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        m_ovf = m_ovf | Cout;
      end
      if (c == clr_c) begin
        m_cnt  = 0;
        m_cnt2 = 0;
        m_ovf  = 1'b0;
      end
    end
  endtask

  // Run press, then reset asserted mid-SETTLE (r cycles into it).
  task automatic reset_mid(input int r);
    for (int c = 0; c <= S + 1 + r; c++) begin
      if (c > 0) begin
        tick();
        check_all(1'b0, 1'b0, c >= S + 1);
      end
      Cout           = 1'b0;
      Run_Accumulate = 1'b0;
      Clear_Button   = 1'b1;
    end
    #2;
    Reset_Clear = 1'b0;
    #1;
    m_cnt  = 0;
    m_cnt2 = 0;
    m_ovf  = 1'b0;
    check_all(1'b0, 1'b0, 1'b0);
    Run_Accumulate = 1'b1;
    tick();
    tick();
    check_all(1'b0, 1'b0, 1'b0);
    Reset_Clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    Reset_Clear    = 1'b0;
    Run_Accumulate = 1'b1;
    Clear_Button   = 1'b1;
    Cout           = 1'b0;
    repeat (3) tick();
    check_all(1'b0, 1'b0, 1'b0);
    Reset_Clear = 1'b1;
    tick();
    check_all(1'b0, 1'b0, 1'b0);

    // Long Run hold: a single load, Busy until release settles.
    txn(1'b1, 1'b0, 20, 0, 1'b1, 1'b0);
    chk("cnt_first", 32'(cnt), 32'd1);

    // Four more loads without carry, then one with carry, then sticky check.
    for (int i = 0; i < 4; i++) txn(1'b1, 1'b0, $urandom_range(1, 12), 0, 1'b1, 1'b0);
    chk("ovf_clean", 32'(ovf), 32'd0);
    txn(1'b1, 1'b0, 3, 0, 1'b1, 1'b1);
    chk("cnt_six", 32'(cnt), 32'd6);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("cnt2_sat", 32'(cnt2), 32'd3);
    txn(1'b1, 1'b0, 5, 0, 1'b1, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Clear press wipes overflow and count.
    txn(1'b0, 1'b1, 4, 0, 1'b1, 1'b0);
    chk("cnt_cleared", 32'(cnt), 32'd0);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Clear two cycles into a run, and on the same edge as a run.
    txn(1'b1, 1'b1, 10, 2, 1'b1, 1'b1);
    txn(1'b1, 1'b1, 6, 0, 1'b1, 1'b1);

    // Reset during SETTLE.
    reset_mid(1);

    // Saturation of the narrow counter: 1, 2, 3, 3, 3.
    for (int i = 0; i < 5; i++) begin
      txn(1'b1, 1'b0, 2, 0, 1'b0, 1'b0);
      chk("cnt2_seq", 32'(cnt2), 32'((i < 3) ? i + 1 : 3));
    end

    // Randomized episodes.
    for (int n = 0; n < 40; n++) begin
      int kind;
      int d;
      kind = $urandom_range(0, 6);
      d    = $urandom_range(0, T);
      case (kind)
        0, 1, 2: txn(1'b1, 1'b0, $urandom_range(1, 25), 0, 1'b0, 1'b0);
        3:       txn(1'b0, 1'b1, $urandom_range(1, 25), 0, 1'b0, 1'b0);
        4, 5:    txn(1'b1, 1'b1, d + $urandom_range(1, 20), d, 1'b0, 1'b0);
        default: reset_mid($urandom_range(0, T - 1));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Control sequencer for the 17-bit switch accumulator: register, adder and router.
- Synchronizes the raw active-low Run and Clear buttons and waits a programmable number of cycles for the adder sum to settle.
- Issues exactly one register-load pulse per Run press, or one clear pulse per Clear press.
- Tracks a sticky overflow flag from the adder carry-out and a saturating count of accumulations, for display on LEDs or HEX.

Parameters:
- SETTLE_CYCLES, 4, cycles waited after Run is accepted before Ld_Reg fires; covers worst-case adder propagation; legal range 1..15.
- SYNC_STAGES, 2, flip-flop depth of each button synchronizer; legal range 2..3.
- COUNT_W, 8, width of Acc_Count.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset_Clear  in  1  asynchronous, active-low reset.
- Run_Accumulate  in  1  raw Run button, active-low, asynchronous to Clk.
- Clear_Button  in  1  raw Clear button, active-low, asynchronous to Clk.
- Cout  in  1  adder carry-out (sum bit 16), valid once settled.
- Ld_Reg  out  1  one-cycle load enable for the accumulator register.
- Clr_Reg  out  1  one-cycle synchronous clear for the accumulator register.
- Busy  out  1  high whenever the FSM is not IDLE.
- Overflow  out  1  sticky carry-out flag.
- Acc_Count  out  COUNT_W  number of completed loads, saturating.

Behaviour:
- Reset (Reset_Clear=0, async):
  - FSM goes to IDLE.
  - Synchronizer flops are set to 1 (buttons released).
  - Settle counter, Ld_Reg, Clr_Reg, Busy and Overflow go to 0; Acc_Count goes to 0.
  - Reset asserted mid-operation aborts it immediately; no Ld_Reg or Clr_Reg pulse is emitted.
  - Reset release is followed by normal operation on the next edge.
- Synchronizers: run_s and clr_s are the SYNC_STAGES-deep synchronized copies of each button. Pressed means synchronized level = 0.
- FSM states: IDLE, SETTLE, LOAD, CLEAR, WAIT_REL.
- IDLE:
  - If clr_s is pressed, go to CLEAR. Clear has priority when both buttons are pressed in the same cycle.
  - Else if run_s is pressed, go to SETTLE and load settle counter = SETTLE_CYCLES-1.
  - Else stay in IDLE.
- SETTLE:
  - If clr_s is pressed, go to CLEAR. This aborts the run; no load occurs.
  - Else if counter = 0, go to LOAD.
  - Else decrement the counter.
  - Total residency is exactly SETTLE_CYCLES cycles.
- LOAD (exactly one cycle):
  - Ld_Reg = 1.
  - Overflow <= Overflow | Cout, with Cout sampled in this cycle.
  - Acc_Count increments, holding at all-ones (2^COUNT_W-1).
  - Next state is WAIT_REL.
- CLEAR (exactly one cycle):
  - Clr_Reg = 1; Overflow <= 0; Acc_Count <= 0.
  - Next state is WAIT_REL.
- WAIT_REL:
  - Stay until run_s and clr_s are both released, then go to IDLE.
  - Button presses arriving in this state are ignored; a button must be released and re-pressed to take effect.
- Ld_Reg and Clr_Reg are never high in the same cycle; both are registered FSM decodes (Moore outputs).
- Busy = (state != IDLE), registered.
- Latency, counted from the first Clk edge that samples the raw Run low:
  - run_s goes low after SYNC_STAGES edges.
  - Ld_Reg is high in cycle SYNC_STAGES + SETTLE_CYCLES + 1.
  - For clear, Clr_Reg is high in cycle SYNC_STAGES + 1.
- Holding Run for any duration produces exactly one Ld_Reg pulse.
- Run pulses shorter than one Clk period may be missed. This is allowed: button inputs only.

Test Plan:
- Reset, then Run low for 20 cycles, defaults (SYNC=2, SETTLE=4):
  - Ld_Reg high only in cycle 7.
  - Acc_Count = 1; Busy high from cycle 3 until 2 cycles after release.
- Five separate Run presses with Cout = 0, then one press with Cout = 1 during LOAD:
  - Acc_Count = 6; Overflow = 1 and stays 1 on a further press with Cout = 0.
- Clear press after the overflow scenario:
  - Clr_Reg is a single pulse in cycle 3; Overflow = 0; Acc_Count = 0; Ld_Reg never asserts.
- Run pressed, then Clear pressed 2 cycles later (during SETTLE):
  - No Ld_Reg; one Clr_Reg; FSM holds in WAIT_REL until both are released.
- Run and Clear pressed on the same edge: Clr_Reg only.
- Reset_Clear pulsed low during SETTLE:
  - Outputs drop to 0 asynchronously; no Ld_Reg; Acc_Count = 0.
- COUNT_W = 2, five presses: Acc_Count sequence 1, 2, 3, 3, 3.
